// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch stage: address/instruction widths,
// the reset PC and the all-zero NOP used as the bubble word.
package fetch_pkg;
  localparam int          ADDR_W_DEFAULT   = 12;
  localparam int          INSN_W_DEFAULT   = 32;
  localparam logic [11:0] RESET_PC_DEFAULT = 12'd0;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer: captures the in-flight imem word on the first
// stalled edge, replays it after the stall, and is dropped on redirect.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int INSN_W = INSN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic [INSN_W-1:0] i_q,
  output logic              o_valid,
  output logic [INSN_W-1:0] o_word
);

  logic [INSN_W-1:0] r_hold;
  logic              r_hold_valid;
  logic              w_take;

  // Only the first stalled edge captures; later ones see imem re-reading pc_q.
  assign w_take = i_capture && !i_clear && !r_hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
    end else if (i_clear) begin
      r_hold_valid <= 1'b0;
    end else if (w_take) begin
      r_hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_hold <= i_q;
    end
  end

  assign o_valid = r_hold_valid;
  assign o_word  = r_hold_valid ? r_hold : i_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, tags imem data with its PC, survives
// decode stalls and flushes on redirect. Optional counters: FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                INSN_W   = INSN_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [INSN_W-1:0] q_imem,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INSN_W-1:0] insn_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              insn_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  logic [ADDR_W-1:0] r_pc_q;
  logic [ADDR_W-1:0] r_pc_d1;
  logic              r_valid_d1;
  logic              w_hold_valid;
  logic [INSN_W-1:0] w_word;
  logic              w_advance;

  assign w_advance = !redirect_valid && !stall;

  fetch_hold_buf #(
    .INSN_W (INSN_W)
  ) u_hold (
    .clk       (clock),
    .rst       (reset),
    .i_capture (stall),
    .i_clear   (redirect_valid || !stall),
    .i_q       (q_imem),
    .o_valid   (w_hold_valid),
    .o_word    (w_word)
  );

  // Stage p0 -> p1: PC issue and the PC/validity of the word imem returns next.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc_q     <= RESET_PC;
      r_pc_d1    <= '0;
      r_valid_d1 <= 1'b0;
    end else if (redirect_valid) begin
      r_pc_q     <= redirect_pc;
      r_valid_d1 <= 1'b0;
    end else if (!stall) begin
      r_pc_q     <= r_pc_q + ADDR_W'(1);
      r_pc_d1    <= r_pc_q;
      r_valid_d1 <= 1'b1;
    end
  end

  // Stage p1 -> p2: registered instruction presented to decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      insn_out   <= '0;
      pc_out     <= '0;
      insn_valid <= 1'b0;
    end else if (redirect_valid) begin
      insn_out   <= INSN_W'(NOP_WORD);
      insn_valid <= 1'b0;
    end else if (!stall) begin
      insn_out   <= r_valid_d1 ? w_word : INSN_W'(NOP_WORD);
      pc_out     <= r_pc_d1;
      insn_valid <= r_valid_d1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (redirect_valid || (w_advance && !r_valid_d1)) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end else if (w_advance) begin
      perf_fetched <= perf_fetched + 32'd1;
    end
  end
`endif

  assign address_imem = r_pc_q;
  assign pc_plus1     = pc_out + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a synchronous imem model where
// mem[a] = a + 0x100; define FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_imem;
  logic [31:0] q_imem = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = 12'h0;
  logic [31:0] insn_out;
  logic [11:0] pc_out;
  logic [11:0] pc_plus1;
  logic        insn_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  int          exp_fetched = 0;
  int          exp_bubbles = 0;
`endif

  typedef struct packed {
    logic        v;
    logic [11:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_out       (insn_out),
    .pc_out         (pc_out),
    .pc_plus1       (pc_plus1),
    .insn_valid     (insn_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'h100 + {20'h0, a};
  endfunction

  always @(posedge clock) q_imem <= mem_word(address_imem);

  // Drive one edge and record the output expected after it.
  task automatic edge_step(input logic s, input logic r, input logic [11:0] rpc,
                           input logic ev, input logic [11:0] epc);
    exp_t e;
    stall = s;
    redirect_valid = r;
    redirect_pc = rpc;
    e.v = ev;
    e.pc = epc;
    e.insn = ev ? mem_word(epc) : 32'h0;
    sb.push_back(e);
`ifdef FETCH_PERF_CNT_EN
    if (!s || r) begin
      if (ev) exp_fetched++;
      else exp_bubbles++;
    end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (insn_valid !== 1'b0 || insn_out !== 32'h0 || pc_out !== 12'h0 || address_imem !== 12'h0) begin
      failures++;
      $display("FAIL reset_state: got v=%0b insn=%h pc=%h addr=%h, want 0/0/0/0",
               insn_valid, insn_out, pc_out, address_imem);
    end
    checks++;
    if (pc_plus1 !== 12'h001) begin
      failures++;
      $display("FAIL reset_pc_plus1: got %h want 001", pc_plus1);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_free_run;
    exp_t e;
    edge_step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) edge_step(0, 0, 0, 1, 12'(i));
    while (sb.size() > 0) begin
      e = sb.pop_front();
    end
  endtask

  // Free-run is checked cycle by cycle here rather than batched.
  task automatic test_free_run_checked;
    exp_t e;
    for (int i = -1; i < 6; i++) begin
      edge_step(0, 0, 0, i >= 0, 12'(i));
      e = sb.pop_front();
      checks++;
      if (insn_valid !== e.v || insn_out !== e.insn ||
          (e.v && (pc_out !== e.pc || pc_plus1 !== e.pc + 12'd1))) begin
        failures++;
        $display("FAIL free_run[%0d]: got v=%0b pc=%h insn=%h p1=%h, want v=%0b pc=%h insn=%h",
                 i, insn_valid, pc_out, insn_out, pc_plus1, e.v, e.pc, e.insn);
      end
    end
  endtask

  task automatic test_stall;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) edge_step(1, 0, 0, 1, 12'd5);
      else edge_step(0, 0, 0, 1, 12'(i + 3));
      e = sb.pop_front();
      checks++;
      if (insn_valid !== e.v || insn_out !== e.insn || pc_out !== e.pc) begin
        failures++;
        $display("FAIL stall[%0d]: got v=%0b pc=%h insn=%h, want v=%0b pc=%h insn=%h",
                 i, insn_valid, pc_out, insn_out, e.v, e.pc, e.insn);
      end
    end
  endtask

  task automatic test_redirect;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) edge_step(0, 1, 12'h040, 0, 0);
      else if (i == 1) edge_step(0, 0, 0, 0, 0);
      else edge_step(0, 0, 0, 1, 12'h040 + 12'(i - 2));
      e = sb.pop_front();
      checks++;
      if (insn_valid !== e.v || insn_out !== e.insn || (e.v && pc_out !== e.pc) ||
          (i == 0 && pc_out !== 12'd7)) begin
        failures++;
        $display("FAIL redirect[%0d]: got v=%0b pc=%h insn=%h, want v=%0b pc=%h insn=%h",
                 i, insn_valid, pc_out, insn_out, e.v, e.pc, e.insn);
      end
    end
  endtask

  task automatic test_redirect_stall;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) edge_step(1, 1, 12'h200, 0, 0);
      else if (i == 1) edge_step(1, 0, 0, 0, 0);
      else if (i == 2) edge_step(0, 0, 0, 0, 0);
      else edge_step(0, 0, 0, 1, 12'h200 + 12'(i - 3));
      e = sb.pop_front();
      checks++;
      if (insn_valid !== e.v || insn_out !== e.insn || (e.v && pc_out !== e.pc)) begin
        failures++;
        $display("FAIL redir_stall[%0d]: got v=%0b pc=%h insn=%h, want v=%0b pc=%h insn=%h",
                 i, insn_valid, pc_out, insn_out, e.v, e.pc, e.insn);
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) edge_step(0, 1, 12'hFFE, 0, 0);
      else if (i == 1) edge_step(0, 0, 0, 0, 0);
      else edge_step(0, 0, 0, 1, 12'hFFE + 12'(i - 2));
      if (i == 0) begin
        checks++;
        if (address_imem !== 12'hFFE) begin
          failures++;
          $display("FAIL wrap_addr: got %h want ffe", address_imem);
        end
      end
      e = sb.pop_front();
      checks++;
      if (insn_valid !== e.v || insn_out !== e.insn ||
          (e.v && (pc_out !== e.pc || pc_plus1 !== e.pc + 12'd1))) begin
        failures++;
        $display("FAIL wrap[%0d]: got v=%0b pc=%h insn=%h p1=%h, want v=%0b pc=%h insn=%h",
                 i, insn_valid, pc_out, insn_out, pc_plus1, e.v, e.pc, e.insn);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'(exp_fetched) || perf_bubbles !== 32'(exp_bubbles)) begin
      failures++;
      $display("FAIL perf_counts: got fetched=%0d bubbles=%0d, want %0d/%0d",
               perf_fetched, perf_bubbles, exp_fetched, exp_bubbles);
    end
`endif
  endtask

  task automatic test_reset_mid;
    exp_t e;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 12'h123;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (insn_valid !== 1'b0 || insn_out !== 32'h0 || pc_out !== 12'h0 || address_imem !== 12'h0) begin
      failures++;
      $display("FAIL async_reset: got v=%0b insn=%h pc=%h addr=%h, want 0/0/0/0",
               insn_valid, insn_out, pc_out, address_imem);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin
      failures++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetched, perf_bubbles);
    end
    exp_fetched = 0;
    exp_bubbles = 0;
`endif
    stall = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = -1; i < 3; i++) begin
      edge_step(0, 0, 0, i >= 0, 12'(i));
      e = sb.pop_front();
      checks++;
      if (insn_valid !== e.v || insn_out !== e.insn || (e.v && pc_out !== e.pc)) begin
        failures++;
        $display("FAIL post_reset[%0d]: got v=%0b pc=%h insn=%h, want v=%0b pc=%h insn=%h",
                 i, insn_valid, pc_out, insn_out, e.v, e.pc, e.insn);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'(exp_fetched) || perf_bubbles !== 32'(exp_bubbles)) begin
      failures++;
      $display("FAIL perf_after_reset: got %0d/%0d want %0d/%0d",
               perf_fetched, perf_bubbles, exp_fetched, exp_bubbles);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_free_run_checked;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
